// File: rtl/pixel_serializer_pkg.sv
// Shared definitions for the pixel-to-byte serializer: FSM states and frame sync bytes.
package pixel_serializer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HDR0  = 2'd1,
    ST_HDR1  = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

endpackage

// File: rtl/pixel_serializer.sv
// Splits multi-byte pixels into a byte stream, optionally preceded by a
// two-byte sync header at the start of every frame.
module pixel_serializer
  import pixel_serializer_pkg::*;
#(
  parameter int bytes_p     = 3,
  parameter int frame_px_p  = 230400,
  parameter int header_en_p = 1,
  localparam int cnt_w      = (frame_px_p > 1) ? $clog2(frame_px_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 valid_i,
  input  logic [8*bytes_p-1:0] data_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [7:0]           data_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic [cnt_w-1:0]     px_count_o
);

  state_t               state_r, state_nxt;
  logic [1:0]           idx_r, idx_nxt;
  logic [cnt_w-1:0]     cnt_r, cnt_nxt, cnt_inc_s;
  logic [8*bytes_p-1:0] px_r, px_nxt, px_shift_s;
  logic                 last_byte_s, xfer_s;

  assign last_byte_s = (idx_r == 2'(bytes_p - 1));
  assign xfer_s      = valid_o && ready_i;
  assign cnt_inc_s   = (cnt_r == cnt_w'(frame_px_p - 1)) ? '0 : cnt_r + cnt_w'(1);
  assign px_shift_s  = px_r >> {idx_r, 3'b000};

  // State, byte index, frame position and latched pixel registers
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r <= ST_EMPTY;
      idx_r   <= 2'd0;
      cnt_r   <= '0;
      px_r    <= '0;
    end else begin
      state_r <= state_nxt;
      idx_r   <= idx_nxt;
      cnt_r   <= cnt_nxt;
      px_r    <= px_nxt;
    end
  end

  // Next-state logic; a new frame (count back at zero) starts with the header
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    cnt_nxt   = cnt_r;
    px_nxt    = px_r;
    case (state_r)
      ST_EMPTY: begin
        if (valid_i) begin
          px_nxt    = data_i;
          idx_nxt   = 2'd0;
          state_nxt = (header_en_p != 0 && cnt_r == '0) ? ST_HDR0 : ST_DATA;
        end else begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_HDR0: begin
        if (xfer_s) state_nxt = ST_HDR1;
        else        state_nxt = ST_HDR0;
      end
      ST_HDR1: begin
        if (xfer_s) state_nxt = ST_DATA;
        else        state_nxt = ST_HDR1;
      end
      ST_DATA: begin
        if (xfer_s && !last_byte_s) begin
          idx_nxt = idx_r + 2'd1;
        end else if (xfer_s) begin
          cnt_nxt = cnt_inc_s;
          if (valid_i) begin
            // Back-to-back accept keeps the stream free of bubbles
            px_nxt    = data_i;
            idx_nxt   = 2'd0;
            state_nxt = (header_en_p != 0 && cnt_inc_s == '0) ? ST_HDR0 : ST_DATA;
          end else begin
            idx_nxt   = 2'd0;
            state_nxt = ST_EMPTY;
          end
        end else begin
          state_nxt = ST_DATA;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    data_o = 8'h00;
    case (state_r)
      ST_EMPTY: data_o = 8'h00;
      ST_HDR0:  data_o = SYNC0;
      ST_HDR1:  data_o = SYNC1;
      ST_DATA:  data_o = px_shift_s[7:0];
      default:  data_o = 8'h00;
    endcase
  end

  assign valid_o    = (state_r != ST_EMPTY);
  assign last_o     = (state_r == ST_DATA) && last_byte_s && (cnt_r == cnt_w'(frame_px_p - 1));
  assign px_count_o = cnt_r;
  assign ready_o    = reset_ni && ((state_r == ST_EMPTY) ||
                                   (state_r == ST_DATA && last_byte_s && ready_i));

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench: one instance with header (frame of 2 pixels), one without (frame of 4).
module tb_pixel_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, val_a, rdyi_a, rdy_a, vo_a, last_a;
  logic [23:0] dat_a;
  logic [7:0]  do_a;
  logic [0:0]  cnt_a;

  logic        rst_b, val_b, rdyi_b, rdy_b, vo_b, last_b;
  logic [23:0] dat_b;
  logic [7:0]  do_b;
  logic [1:0]  cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;

  pixel_serializer #(.bytes_p(3), .frame_px_p(2), .header_en_p(1)) dut_a (
    .clk_i(clk), .reset_ni(rst_a), .valid_i(val_a), .data_i(dat_a), .ready_o(rdy_a),
    .valid_o(vo_a), .data_o(do_a), .ready_i(rdyi_a), .last_o(last_a), .px_count_o(cnt_a)
  );

  pixel_serializer #(.bytes_p(3), .frame_px_p(4), .header_en_p(0)) dut_b (
    .clk_i(clk), .reset_ni(rst_b), .valid_i(val_b), .data_i(dat_b), .ready_o(rdy_b),
    .valid_o(vo_b), .data_o(do_b), .ready_i(rdyi_b), .last_o(last_b), .px_count_o(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_a(input string tag, input logic v, input logic [7:0] d,
                       input logic l, input logic r);
    #1;
    check({tag, ".valid"}, 32'(vo_a), 32'(v));
    check({tag, ".data"},  32'(do_a), 32'(d));
    check({tag, ".last"},  32'(last_a), 32'(l));
    check({tag, ".ready"}, 32'(rdy_a), 32'(r));
  endtask

  task automatic exp_b(input string tag, input logic v, input logic [7:0] d,
                       input logic l, input logic r);
    #1;
    check({tag, ".valid"}, 32'(vo_b), 32'(v));
    check({tag, ".data"},  32'(do_b), 32'(d));
    check({tag, ".last"},  32'(last_b), 32'(l));
    check({tag, ".ready"}, 32'(rdy_b), 32'(r));
  endtask

  initial begin
    rst_a = 1'b0; val_a = 1'b1; dat_a = 24'h332211; rdyi_a = 1'b1;
    rst_b = 1'b0; val_b = 1'b0; dat_b = 24'h0;      rdyi_b = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    // Reset state, with valid_i held high throughout
    exp_a("rst", 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst.cnt", 32'(cnt_a), 32'd0);
    rst_a = 1'b1;
    exp_a("rel", 1'b0, 8'h00, 1'b0, 1'b1);

    // Frame 0: header, pixel 0x332211, pixel 0x665544 back-to-back
    next_cyc(); dat_a = 24'h665544; exp_a("f0.hdr0", 1'b1, 8'hA5, 1'b0, 1'b0);
    next_cyc(); exp_a("f0.hdr1", 1'b1, 8'h5A, 1'b0, 1'b0);
    next_cyc(); exp_a("p0.b0",   1'b1, 8'h11, 1'b0, 1'b0);
    next_cyc(); exp_a("p0.b1",   1'b1, 8'h22, 1'b0, 1'b0);
    next_cyc(); exp_a("p0.b2",   1'b1, 8'h33, 1'b0, 1'b1);
    check("p0.cnt", 32'(cnt_a), 32'd0);
    next_cyc(); dat_a = 24'h998877; exp_a("p1.b0", 1'b1, 8'h44, 1'b0, 1'b0);
    check("p1.cnt", 32'(cnt_a), 32'd1);
    next_cyc(); exp_a("p1.b1", 1'b1, 8'h55, 1'b0, 1'b0);
    next_cyc(); exp_a("p1.b2", 1'b1, 8'h66, 1'b1, 1'b1);

    // Frame 1 starts immediately after 0x66
    next_cyc(); val_a = 1'b0; exp_a("f1.hdr0", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("f1.cnt", 32'(cnt_a), 32'd0);
    next_cyc(); exp_a("f1.hdr1", 1'b1, 8'h5A, 1'b0, 1'b0);
    next_cyc(); exp_a("p2.b0",   1'b1, 8'h77, 1'b0, 1'b0);
    next_cyc(); exp_a("p2.b1",   1'b1, 8'h88, 1'b0, 1'b0);
    next_cyc(); exp_a("p2.b2",   1'b1, 8'h99, 1'b0, 1'b1);
    next_cyc(); val_a = 1'b1; dat_a = 24'h332211;
    exp_a("idle1", 1'b0, 8'h00, 1'b0, 1'b1);
    check("idle1.cnt", 32'(cnt_a), 32'd1);

    // Downstream stall on the middle byte
    next_cyc(); val_a = 1'b0; exp_a("st.b0", 1'b1, 8'h11, 1'b0, 1'b0);
    next_cyc(); rdyi_a = 1'b0; exp_a("st.hold0", 1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_cyc(); exp_a("st.hold", 1'b1, 8'h22, 1'b0, 1'b0);
    end
    next_cyc(); rdyi_a = 1'b1; exp_a("st.go", 1'b1, 8'h22, 1'b0, 1'b0);
    next_cyc(); exp_a("st.b2", 1'b1, 8'h33, 1'b1, 1'b1);
    next_cyc(); val_a = 1'b1; dat_a = 24'h332211;
    exp_a("idle2", 1'b0, 8'h00, 1'b0, 1'b1);
    check("idle2.cnt", 32'(cnt_a), 32'd0);

    // Reset in the middle of a pixel drops the remaining byte
    next_cyc(); val_a = 1'b0; exp_a("rm.hdr0", 1'b1, 8'hA5, 1'b0, 1'b0);
    next_cyc(); exp_a("rm.hdr1", 1'b1, 8'h5A, 1'b0, 1'b0);
    next_cyc(); exp_a("rm.b0",   1'b1, 8'h11, 1'b0, 1'b0);
    next_cyc(); exp_a("rm.b1",   1'b1, 8'h22, 1'b0, 1'b0);
    next_cyc(); rst_a = 1'b0; exp_a("rm.inrst", 1'b1, 8'h33, 1'b0, 1'b0);
    next_cyc(); rst_a = 1'b1; val_a = 1'b1; dat_a = 24'hCCBBAA;
    exp_a("rm.after", 1'b0, 8'h00, 1'b0, 1'b1);
    check("rm.cnt", 32'(cnt_a), 32'd0);
    next_cyc(); val_a = 1'b0; exp_a("rn.hdr0", 1'b1, 8'hA5, 1'b0, 1'b0);
    next_cyc(); exp_a("rn.hdr1", 1'b1, 8'h5A, 1'b0, 1'b0);
    next_cyc(); exp_a("rn.b0",   1'b1, 8'hAA, 1'b0, 1'b0);
    next_cyc(); exp_a("rn.b1",   1'b1, 8'hBB, 1'b0, 1'b0);
    next_cyc(); exp_a("rn.b2",   1'b1, 8'hCC, 1'b0, 1'b1);
    next_cyc(); exp_a("rn.idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // Headerless streaming: pixel n carries bytes 3n+1..3n+3
    rst_b = 1'b1; val_b = 1'b1; dat_b = 24'h030201;
    exp_b("nh.idle0", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      next_cyc();
      if (k / 3 + 1 < 4) begin
        dat_b = {8'(3 * (k / 3 + 1) + 3), 8'(3 * (k / 3 + 1) + 2), 8'(3 * (k / 3 + 1) + 1)};
        val_b = 1'b1;
      end else begin
        val_b = 1'b0;
      end
      exp_b($sformatf("nh.k%0d", k), 1'b1, 8'(k + 1), (k == 11), (k % 3 == 2));
      if (k == 3) check("nh.cnt_mid", 32'(cnt_b), 32'd1);
    end
    next_cyc(); exp_b("nh.end", 1'b0, 8'h00, 1'b0, 1'b1);
    check("nh.cnt_wrap", 32'(cnt_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
